// File: rtl/csrng_ctr_drbg_gen_seq.sv
// rtl/csrng_ctr_drbg_gen_seq.sv - ctr_drbg generate-stage sequencer: V increment, block encrypt, genbits, final update
module csrng_ctr_drbg_gen_seq #(
    parameter int Cmd     = 3,
    parameter int StateId = 4,
    parameter int BlkLen  = 128,
    parameter int KeyLen  = 256,
    parameter int SeedLen = 384,
    parameter int CtrLen  = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               enable_i,
    input  logic               req_i,
    output logic               rdy_o,
    input  logic [Cmd-1:0]     ccmd_i,
    input  logic [StateId-1:0] inst_id_i,
    input  logic               glast_i,
    input  logic               fips_i,
    input  logic [SeedLen-1:0] adata_i,
    input  logic [KeyLen-1:0]  key_i,
    input  logic [BlkLen-1:0]  v_i,
    input  logic [CtrLen-1:0]  rc_i,
    output logic               benc_req_o,
    input  logic               benc_rdy_i,
    output logic [KeyLen-1:0]  benc_key_o,
    output logic [BlkLen-1:0]  benc_v_o,
    input  logic               benc_ack_i,
    input  logic [BlkLen-1:0]  benc_data_i,
    output logic               genbits_vld_o,
    input  logic               genbits_rdy_i,
    output logic [BlkLen-1:0]  genbits_o,
    output logic               genbits_fips_o,
    output logic               upd_req_o,
    input  logic               upd_rdy_i,
    output logic [SeedLen-1:0] upd_pdata_o,
    output logic [KeyLen-1:0]  upd_key_o,
    output logic [BlkLen-1:0]  upd_v_o,
    input  logic               upd_ack_i,
    input  logic [KeyLen-1:0]  upd_key_i,
    input  logic [BlkLen-1:0]  upd_v_i,
    output logic               ack_o,
    input  logic               ack_rdy_i,
    output logic [Cmd-1:0]     ccmd_o,
    output logic [StateId-1:0] inst_id_o,
    output logic               fips_o,
    output logic [KeyLen-1:0]  key_o,
    output logic [BlkLen-1:0]  v_o,
    output logic [CtrLen-1:0]  rc_o,
    output logic               err_o
);

    localparam logic [Cmd-1:0] GenCmd = Cmd'(3);

    // Sparse encoding so a corrupted state register is detectable.
    typedef enum logic [4:0] {
        IDLE     = 5'h00,
        ENC_REQ  = 5'h03,
        ENC_WAIT = 5'h05,
        BITS     = 5'h06,
        UPD_REQ  = 5'h09,
        UPD_WAIT = 5'h0a,
        DONE     = 5'h0c
    } state_e;

    state_e               state_q, state_d;
    logic                 err_q, err_d;
    logic                 rdy_q, rdy_d;
    logic [Cmd-1:0]       ccmd_q, ccmd_d;
    logic [StateId-1:0]   inst_id_q, inst_id_d;
    logic                 glast_q, glast_d;
    logic                 fips_q, fips_d;
    logic [SeedLen-1:0]   adata_q, adata_d;
    logic [KeyLen-1:0]    key_q, key_d;
    logic [BlkLen-1:0]    v_q, v_d;
    logic [CtrLen-1:0]    rc_q, rc_d;
    logic [BlkLen-1:0]    bits_q, bits_d;
    logic                 capture;

    assign capture = req_i && rdy_q && enable_i;

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        ccmd_d    = ccmd_q;
        inst_id_d = inst_id_q;
        glast_d   = glast_q;
        fips_d    = fips_q;
        adata_d   = adata_q;
        key_d     = key_q;
        v_d       = v_q;
        rc_d      = rc_q;
        bits_d    = bits_q;

        case (state_q)
            IDLE: begin
                if (capture) begin
                    ccmd_d    = ccmd_i;
                    inst_id_d = inst_id_i;
                    glast_d   = glast_i;
                    fips_d    = fips_i;
                    adata_d   = adata_i;
                    key_d     = key_i;
                    v_d       = v_i;
                    rc_d      = rc_i;
                    if (ccmd_i == GenCmd) begin
                        // Only the counter field of V increments; upper bits are fixed.
                        v_d[CtrLen-1:0] = v_i[CtrLen-1:0] + CtrLen'(1);
                        state_d         = ENC_REQ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ENC_REQ: begin
                if (benc_rdy_i) state_d = ENC_WAIT;
            end
            ENC_WAIT: begin
                if (benc_ack_i) begin
                    bits_d  = benc_data_i;
                    state_d = BITS;
                end
            end
            BITS: begin
                if (genbits_rdy_i) state_d = glast_q ? UPD_REQ : DONE;
            end
            UPD_REQ: begin
                if (upd_rdy_i) state_d = UPD_WAIT;
            end
            UPD_WAIT: begin
                if (upd_ack_i) begin
                    key_d   = upd_key_i;
                    v_d     = upd_v_i;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ack_rdy_i) state_d = IDLE;
            end
            default: begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
        endcase

        if (!enable_i) begin
            state_d   = IDLE;
            ccmd_d    = '0;
            inst_id_d = '0;
            glast_d   = 1'b0;
            fips_d    = 1'b0;
            adata_d   = '0;
            key_d     = '0;
            v_d       = '0;
            rc_d      = '0;
            bits_d    = '0;
        end

        rdy_d = enable_i && (state_d == IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            err_q     <= 1'b0;
            rdy_q     <= 1'b0;
            ccmd_q    <= '0;
            inst_id_q <= '0;
            glast_q   <= 1'b0;
            fips_q    <= 1'b0;
            adata_q   <= '0;
            key_q     <= '0;
            v_q       <= '0;
            rc_q      <= '0;
            bits_q    <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            rdy_q     <= rdy_d;
            ccmd_q    <= ccmd_d;
            inst_id_q <= inst_id_d;
            glast_q   <= glast_d;
            fips_q    <= fips_d;
            adata_q   <= adata_d;
            key_q     <= key_d;
            v_q       <= v_d;
            rc_q      <= rc_d;
            bits_q    <= bits_d;
        end
    end

    assign rdy_o          = rdy_q;
    assign err_o          = err_q;
    assign benc_req_o     = (state_q == ENC_REQ);
    assign benc_key_o     = key_q;
    assign benc_v_o       = v_q;
    assign genbits_vld_o  = (state_q == BITS);
    assign genbits_o      = bits_q;
    assign genbits_fips_o = fips_q && (state_q == BITS);
    assign upd_req_o      = (state_q == UPD_REQ);
    assign upd_pdata_o    = adata_q;
    assign upd_key_o      = key_q;
    assign upd_v_o        = v_q;
    assign ack_o          = (state_q == DONE);
    assign ccmd_o         = ccmd_q;
    assign inst_id_o      = inst_id_q;
    assign fips_o         = fips_q;
    assign key_o          = key_q;
    assign v_o            = v_q;
    // The reseed counter advances once per completed GEN, saturating.
    assign rc_o           = (ccmd_q == GenCmd && glast_q && rc_q != '1) ? rc_q + CtrLen'(1) : rc_q;

endmodule

// File: doc/csrng_ctr_drbg_gen_seq.md
# csrng_ctr_drbg_gen_seq

Generate-stage sequencer placed directly downstream of the CSRNG ctr_drbg command stage. It takes each completed command beat with its post-update key, V, reseed counter and additional data. For GEN beats it increments V, drives one block-encrypt request, and emits one 128-bit genbits word. On the last beat of a GEN it runs the final ctr_drbg update and returns the new working state. Non-GEN commands pass straight to the completion interface with their state unchanged.

## Interface
- Cmd, 3: command code width (INS/RES/GEN/UPD/UNI from csrng_pkg).
- StateId, 4: instance id width.
- BlkLen, 128: V / cipher block width.
- KeyLen, 256: key width.
- SeedLen, 384: additional-data width.
- CtrLen, 32: reseed counter width and V increment field width.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- enable_i  in  1  block enable; low acts as synchronous clear.
- req_i / rdy_o  in/out  1  input beat handshake.
- ccmd_i, inst_id_i, glast_i, fips_i  in  Cmd/StateId/1/1  command code, instance id, last-beat flag, fips flag.
- adata_i, key_i, v_i, rc_i  in  SeedLen/KeyLen/BlkLen/CtrLen  input working state.
- benc_req_o / benc_rdy_i  out/in  1  cipher request handshake.
- benc_key_o, benc_v_o  out  KeyLen/BlkLen  cipher key and plaintext.
- benc_ack_i  in  1  cipher result valid.
- benc_data_i  in  BlkLen  cipher result.
- genbits_vld_o / genbits_rdy_i  out/in  1  random-word handshake.
- genbits_o  out  BlkLen  random word.
- genbits_fips_o  out  1  fips flag of the word.
- upd_req_o / upd_rdy_i  out/in  1  update request handshake.
- upd_pdata_o, upd_key_o, upd_v_o  out  SeedLen/KeyLen/BlkLen  update inputs.
- upd_ack_i  in  1  update result valid.
- upd_key_i, upd_v_i  in  KeyLen/BlkLen  update results.
- ack_o / ack_rdy_i  out/in  1  completion handshake.
- ccmd_o, inst_id_o, fips_o  out  Cmd/StateId/1  completion command, id and fips flag.
- key_o, v_o, rc_o  out  KeyLen/BlkLen/CtrLen  completion working state.
- err_o  out  1  illegal FSM state, sticky until reset.

## Operation
- Capture: the input beat is registered when req_i && rdy_o, and only then.
- FSM states: IDLE, ENC_REQ, ENC_WAIT, BITS, UPD_REQ, UPD_WAIT, DONE. Encoding is sparse; any unlisted encoding sets err_o and forces IDLE.
- IDLE: rdy_o = enable_i.
  - On capture of a GEN beat, set V := V+1 and go to ENC_REQ.
  - On capture of any other command, go to DONE with state unchanged.
- V increment: the low CtrLen bits wrap modulo 2^CtrLen; the upper BlkLen-CtrLen bits never change.
- ENC_REQ: benc_req_o=1 with the registered key and V. Go to ENC_WAIT on benc_rdy_i.
- ENC_WAIT: on benc_ack_i, latch benc_data_i and go to BITS.
- BITS: genbits_vld_o=1, genbits_fips_o = registered fips. On genbits_rdy_i:
  - glast=0: go to DONE.
  - glast=1: go to UPD_REQ.
- UPD_REQ: upd_req_o=1 with pdata=adata, key, V. Go to UPD_WAIT on upd_rdy_i.
- UPD_WAIT: on upd_ack_i, latch upd_key_i/upd_v_i and go to DONE.
- DONE: ack_o=1. Outputs carry the registered command, id, fips, key and V.
  - rc_o = rc+1, saturating at all-ones, for a GEN with glast=1.
  - rc_o = rc unchanged in every other case.
  - On ack_rdy_i, go to IDLE.
- Non-last GEN beats return the incremented V so the command stage stores it for the next beat.
- enable_i=0: next edge forces IDLE, clears all data registers and drops all request/valid outputs. Any in-flight cipher or update ack is ignored. err_o is not cleared.

## Timing
- Reset values: every output 0 (including rdy_o and err_o); state IDLE.
- All outputs are driven from registers or state decode only; there is no combinational path from input to output.
- Latency with zero downstream stall:
  - Capture to benc_req_o: 1 cycle.
  - benc_ack_i to genbits_vld_o: 1 cycle.
  - genbits handshake to ack_o (non-last): 1 cycle.
  - Non-GEN capture to ack_o: 1 cycle.
- Each req/vld output holds with its data stable until the matching rdy is seen. It drops on the cycle after the handshake.
- Only one command is in flight; rdy_o=0 outside IDLE. A req_i asserted while rdy_o=0 is held off, not dropped.
- benc_ack_i or upd_ack_i outside its WAIT state is ignored.
- A simultaneous handshake and enable_i=0: disable wins.

## Test plan
- INS beat (key=K, v=V, rc=5) -> ack_o 1 cycle after capture with key=K, v=V, rc=5, no benc_req_o.
- GEN glast=0, v=...0000_0005, benc_data=D -> benc_v_o=...0006, genbits_o=D, ack with v=...0006, rc unchanged, no upd_req_o.
- GEN glast=1, adata=A, rc=7, upd returns K2/V2 -> upd_pdata_o=A, ack key=K2, v=V2, rc=8.
- Wrap/saturate: low 32 bits of v = FFFFFFFF -> benc_v_o low=00000000, upper bits unchanged; rc=FFFFFFFF with glast=1 -> rc_o=FFFFFFFF.
- genbits_rdy_i held low 10 cycles -> genbits_o stable with vld high throughout, rdy_o stays 0.
- enable_i dropped in ENC_WAIT, late benc_ack_i -> IDLE next cycle, no genbits_vld_o, all outputs 0.
